// File: rtl/store_merge_unit_pkg.sv
// Shared store-size encodings, FSM state type and the alignment check for
// the sub-word store engine.
package store_merge_unit_pkg;

    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

    typedef enum logic [2:0] {
        SMU_IDLE  = 3'd0,
        SMU_READ  = 3'd1,
        SMU_WAIT  = 3'd2,
        SMU_WRITE = 3'd3,
        SMU_DONE  = 3'd4
    } smu_state_e;

    // A request is rejected when its size code is reserved or the byte
    // offset does not fall on a natural boundary for that size.
    function automatic logic st_illegal(input logic [1:0] size,
                                        input logic [1:0] byte_off);
        logic bad;
        case (size)
            ST_BYTE: bad = 1'b0;
            ST_HALF: bad = byte_off[0];
            ST_WORD: bad = (byte_off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge_unit_st_merge.sv
// Combinational lane merge: replaces the addressed byte/half of an old word
// with the low bits of the store data (little-endian lanes).
module st_merge
    import store_merge_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  st_size,
    input  logic [1:0]  byte_off,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (st_size)
            ST_BYTE: begin
                case (byte_off)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            ST_HALF: begin
                if (byte_off[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            ST_WORD: merged = wdata;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store engine for a word-only memory: word stores write directly, byte/half
// stores read-modify-write, misaligned or reserved requests are rejected.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        st_size,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    smu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              bad_q, bad_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [31:0]       merged;

    st_merge u_merge (
        .old_word (mem_rdata),
        .wdata    (wdata_q),
        .st_size  (size_q),
        .byte_off (addr_q[1:0]),
        .merged   (merged)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        bad_d   = bad_q;
        wbuf_d  = wbuf_q;
        case (state_q)
            SMU_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    size_d  = st_size;
                    bad_d   = st_illegal(st_size, addr[1:0]);
                    // Word stores write the operand as-is; sub-word stores
                    // overwrite the buffer once the read data returns.
                    wbuf_d  = wdata;
                    if (st_illegal(st_size, addr[1:0])) begin
                        state_d = SMU_DONE;
                    end else if (st_size == ST_WORD) begin
                        state_d = SMU_WRITE;
                    end else begin
                        state_d = SMU_READ;
                    end
                end
            end
            SMU_READ:  state_d = SMU_WAIT;
            SMU_WAIT: begin
                if (mem_rvalid) begin
                    wbuf_d  = merged;
                    state_d = SMU_WRITE;
                end
            end
            SMU_WRITE: state_d = SMU_DONE;
            SMU_DONE:  state_d = SMU_IDLE;
            default:   state_d = SMU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SMU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            bad_q   <= 1'b0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            bad_q   <= bad_d;
            wbuf_q  <= wbuf_d;
        end
    end

    assign busy      = (state_q != SMU_IDLE);
    assign done      = (state_q == SMU_DONE);
    assign misalign  = (state_q == SMU_DONE) && bad_q;
    assign mem_rd    = (state_q == SMU_READ);
    assign mem_we    = (state_q == SMU_WRITE);
    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_wdata = wbuf_q;

endmodule
